mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory interface stage between the Mini SRC single bus and word-addressed RAM.
//  Holds the Memory Address Register (MAR) and Memory Data Register (MDR).
//  Runs read/write transactions over a req/ack handshake with variable wait states.
//  Control unit issues one-cycle rd_req/wr_req pulses and holds off on busy until done.
// PARAMETERS
//  DATA_W     32   bus/MDR/memory data width
//  ADDR_W     9    memory address width; MAR = bus_in[ADDR_W-1:0] (512 words)
//  TIMEOUT    15   max cycles waiting for mem_ack (MEM_TIMEOUT_EN only), >=1
// PORTS
//  clk        in   1       system clock, rising edge
//  clr        in   1       asynchronous reset, active-low
//  bus_in     in   DATA_W  value on the datapath bus
//  mar_in     in   1       load MAR from bus_in[ADDR_W-1:0]
//  mdr_in     in   1       load MDR from bus_in
//  rd_req     in   1       start memory read (1-cycle pulse)
//  wr_req     in   1       start memory write (1-cycle pulse)
//  mdr_q      out  DATA_W  MDR contents, drives bus mux
//  mar_q      out  ADDR_W  MAR contents
//  busy       out  1       transaction in progress (state != IDLE)
//  done       out  1       1-cycle pulse: transaction complete
//  err        out  1       1-cycle pulse: illegal request or timeout
//  mem_addr   out  ADDR_W  = mar_q
//  mem_wdata  out  DATA_W  = mdr_q
//  mem_req    out  1       registered request, held until ack
//  mem_we     out  1       registered write strobe, valid with mem_req
//  mem_rdata  in   DATA_W  read data, valid when mem_ack=1
//  mem_ack    in   1       memory completion, sampled while mem_req=1
// BEHAVIOUR
//  Reset (clr=0, async): MAR=0, MDR=0, state=IDLE; busy, done, err, mem_req, mem_we = 0.
//  Reset mid-transaction: mem_req drops immediately, MDR not updated, no done pulse.
//  FSM: IDLE -> REQ -> DONE -> IDLE.
//   IDLE: rd_req xor wr_req -> REQ with mem_req=1, mem_we=wr_req on the next edge.
//   IDLE: rd_req & wr_req same cycle -> no access, err=1 for 1 cycle, remain IDLE.
//   REQ:  mem_ack=1 -> DONE; on read, MDR<=mem_rdata on that edge.
//   REQ:  mem_req/mem_we/mem_addr/mem_wdata are held stable until mem_ack.
//   DONE: done=1, mem_req=0 for one cycle -> IDLE.
//  Latency: req pulse at edge N, ack at N+k (k>=1): mem_req high N+1..N+k; done
//   high N+k+1; read data visible on mdr_q in that same cycle.
//  Back-to-back: a new rd_req/wr_req is accepted in the cycle done=1 (the FSM
//   returns to IDLE on the edge that sees it).
//  mar_in/mdr_in: honoured only in IDLE and DONE; ignored while in REQ.
//  rd_req/wr_req: ignored while in REQ.
//  mdr_in with rd_req in IDLE: MDR loads bus_in, then the read overwrites it at ack.
//  mem_ack outside REQ is ignored.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter cleared on entry to REQ, incremented each REQ cycle.
//   Reaching TIMEOUT cycles without mem_ack: mem_req=0, err=1 for 1 cycle, -> IDLE,
//   no done pulse, MDR unchanged.
//  Undefined: no counter; REQ waits indefinitely; err only flags an illegal request.
// TESTING
//  1 mar_in, bus=0x05; rd_req; mem_ack after 3 cycles with rdata=0xDEADBEEF
//    -> mem_addr=5, mem_we=0; done 1 cycle after ack; mdr_q=0xDEADBEEF.
//  2 MAR=0x1FF, mdr_in, bus=0x12345678; wr_req; ack in first REQ cycle
//    -> mem_we=1, mem_wdata=0x12345678; done at N+2.
//  3 rd_req & wr_req together -> err pulse; mem_req stays 0; busy 0.
//  4 During REQ drive mdr_in bus=0xAAAA and mar_in bus=0x3
//    -> mdr_q, mar_q unchanged until done.
//  5 clr low during REQ -> mem_req=0 asynchronously; mdr_q=0; no done.
//  6 MEM_TIMEOUT_EN, TIMEOUT=15, no ack -> err after 15 REQ cycles, IDLE; undefined: busy stays 1.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module  : mem_access_unit_if
// Purpose : req/ack word-RAM bus between the memory access unit and RAM.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Purpose : MAR/MDR holding stage running req/ack RAM transactions for the bus.
//           Optional feature macro: MEM_TIMEOUT_EN (abort REQ after TIMEOUT cycles).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  wire logic              clk,
  input  wire logic              clr,
  input  wire logic [DATA_W-1:0] bus_in,
  input  wire logic              mar_in,
  input  wire logic              mdr_in,
  input  wire logic              rd_req,
  input  wire logic              wr_req,
  output logic      [DATA_W-1:0] mdr_q,
  output logic      [ADDR_W-1:0] mar_q,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  mem_access_unit_if.master      mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_d;
  logic [DATA_W-1:0] mdr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_REQ: begin
        if (mem.mem_ack) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            mdr_d = mem.mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        // IDLE and DONE behave alike so a request in the done cycle is taken at once
        state_d = ST_IDLE;
        if (mar_in) begin
          mar_d = bus_in[ADDR_W-1:0];
        end
        if (mdr_in) begin
          mdr_d = bus_in;
        end
        if (rd_req && wr_req) begin
          err_d = 1'b1;
        end else if (rd_req || wr_req) begin
          state_d   = ST_REQ;
          mem_req_d = 1'b1;
          mem_we_d  = wr_req;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Scoreboard bench for mem_access_unit (honours MEM_TIMEOUT_EN).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mdr;
  } exp_t;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] bus_in = '0;
  logic              mar_in = 1'b0;
  logic              mdr_in = 1'b0;
  logic              rd_req = 1'b0;
  logic              wr_req = 1'b0;
  logic [DATA_W-1:0] mdr_q;
  logic [ADDR_W-1:0] mar_q;
  logic              busy;
  logic              done;
  logic              err;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .clr    (clr),
    .bus_in (bus_in),
    .mar_in (mar_in),
    .mdr_in (mdr_in),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .mdr_q  (mdr_q),
    .mar_q  (mar_q),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .mem    (mif)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail   = 0;
  exp_t              sb[$];
  logic [ADDR_W-1:0] mar_m = '0;
  logic [DATA_W-1:0] mdr_m = '0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_reg(input logic to_mar, input logic [DATA_W-1:0] val);
    bus_in = val;
    mar_in = to_mar;
    mdr_in = !to_mar;
    tick();
    mar_in = 1'b0;
    mdr_in = 1'b0;
    if (to_mar) mar_m = val[ADDR_W-1:0];
    else        mdr_m = val;
  endtask

  // Leaves the bench in the done cycle so a caller may chain another request.
  task automatic access(input string tag, input logic we, input int k,
                        input logic [DATA_W-1:0] rdata);
    exp_t e;
    e.we    = we;
    e.addr  = mar_m;
    e.wdata = mdr_m;
    e.mdr   = we ? mdr_m : rdata;
    sb.push_back(e);
    mdr_m = e.mdr;
    rd_req = !we;
    wr_req = we;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    check_eq({tag, "_req"},   {31'd0, mif.mem_req}, 32'd1);
    check_eq({tag, "_busy"},  {31'd0, busy},        32'd1);
    check_eq({tag, "_we"},    {31'd0, mif.mem_we},  {31'd0, sb[0].we});
    check_eq({tag, "_addr"},  {23'd0, mif.mem_addr}, {23'd0, sb[0].addr});
    if (we) check_eq({tag, "_wdata"}, mif.mem_wdata, sb[0].wdata);
    for (int i = 1; i < k; i++) begin
      tick();
      check_eq({tag, "_req_hold"}, {31'd0, mif.mem_req}, 32'd1);
      check_eq({tag, "_done_early"}, {31'd0, done}, 32'd0);
    end
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = rdata;
    tick();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    e = sb.pop_front();
    check_eq({tag, "_done"},     {31'd0, done},        32'd1);
    check_eq({tag, "_req_drop"}, {31'd0, mif.mem_req}, 32'd0);
    check_eq({tag, "_mdr"},      mdr_q,                e.mdr);
  endtask

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;

    #12;
    check_eq("rst_mar",  {23'd0, mar_q},       32'd0);
    check_eq("rst_mdr",  mdr_q,                32'd0);
    check_eq("rst_busy", {31'd0, busy},        32'd0);
    check_eq("rst_req",  {31'd0, mif.mem_req}, 32'd0);
    check_eq("rst_flags", {29'd0, done, err, mif.mem_we}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    tick();

    // Read with three wait cycles
    load_reg(1'b1, 32'h0000_0005);
    access("t1_rd", 1'b0, 3, 32'hDEAD_BEEF);
    tick();
    check_eq("t1_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("t1_idle_done", {31'd0, done}, 32'd0);

    // Write acked in first REQ cycle, then an immediate back-to-back read
    load_reg(1'b1, 32'h0000_01FF);
    load_reg(1'b0, 32'h1234_5678);
    access("t2_wr", 1'b1, 1, 32'h0BAD_0BAD);
    access("t2_b2b", 1'b0, 2, 32'hCAFE_F00D);
    tick();

    // Simultaneous read and write request is illegal
    rd_req = 1'b1;
    wr_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    check_eq("t3_err",  {31'd0, err},         32'd1);
    check_eq("t3_req",  {31'd0, mif.mem_req}, 32'd0);
    check_eq("t3_busy", {31'd0, busy},        32'd0);
    tick();
    check_eq("t3_err_pulse", {31'd0, err}, 32'd0);

    // MAR/MDR loads are ignored while a request is outstanding
    load_reg(1'b1, 32'h0000_0010);
    load_reg(1'b0, 32'h5555_0000);
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    bus_in = 32'h0000_AAAA;
    mdr_in = 1'b1;
    tick();
    mdr_in = 1'b0;
    bus_in = 32'h0000_0003;
    mar_in = 1'b1;
    tick();
    mar_in = 1'b0;
    check_eq("t4_mdr_hold", mdr_q,              32'h5555_0000);
    check_eq("t4_mar_hold", {23'd0, mar_q},     32'h0000_0010);
    check_eq("t4_wdata",    mif.mem_wdata,      32'h5555_0000);
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    check_eq("t4_done",     {31'd0, done},      32'd1);
    check_eq("t4_mdr_end",  mdr_q,              32'h5555_0000);
    tick();

    // mdr_in together with rd_req: bus value first, then read data
    bus_in = 32'h1111_2222;
    mdr_in = 1'b1;
    rd_req = 1'b1;
    tick();
    mdr_in = 1'b0;
    rd_req = 1'b0;
    check_eq("t7_mdr_pre", mdr_q, 32'h1111_2222);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h3333_4444;
    tick();
    mif.mem_ack   = 1'b0;
    check_eq("t7_mdr_post", mdr_q, 32'h3333_4444);
    mdr_m = 32'h3333_4444;
    tick();

    // Stray ack while idle does nothing
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hFFFF_FFFF;
    tick();
    mif.mem_ack   = 1'b0;
    check_eq("t8_busy", {31'd0, busy}, 32'd0);
    check_eq("t8_done", {31'd0, done}, 32'd0);
    check_eq("t8_mdr",  mdr_q,         32'h3333_4444);

    // No ack at all for TIMEOUT cycles
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (TIMEOUT - 1) tick();
    check_eq("t6_req_last", {31'd0, mif.mem_req}, 32'd1);
    check_eq("t6_err_early", {31'd0, err}, 32'd0);
    tick();
`ifdef MEM_TIMEOUT_EN
    check_eq("t6_err",  {31'd0, err},         32'd1);
    check_eq("t6_busy", {31'd0, busy},        32'd0);
    check_eq("t6_req",  {31'd0, mif.mem_req}, 32'd0);
    check_eq("t6_done", {31'd0, done},        32'd0);
    check_eq("t6_mdr",  mdr_q,                32'h3333_4444);
    tick();
`else
    repeat (5) tick();
    check_eq("t6_busy", {31'd0, busy},        32'd1);
    check_eq("t6_req",  {31'd0, mif.mem_req}, 32'd1);
    check_eq("t6_err",  {31'd0, err},         32'd0);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h7777_8888;
    tick();
    mif.mem_ack   = 1'b0;
    check_eq("t6_done", {31'd0, done}, 32'd1);
    check_eq("t6_mdr",  mdr_q,         32'h7777_8888);
    tick();
`endif

    // Asynchronous reset in the middle of a read
    load_reg(1'b1, 32'h0000_0042);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    check_eq("t5_req_before", {31'd0, mif.mem_req}, 32'd1);
    #2;
    clr = 1'b0;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h9999_9999;
    #1;
    check_eq("t5_req_async", {31'd0, mif.mem_req}, 32'd0);
    check_eq("t5_mdr",  mdr_q,         32'd0);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    mif.mem_ack = 1'b0;
    tick();
    check_eq("t5_no_done", {31'd0, done},   32'd0);
    check_eq("t5_mar",     {23'd0, mar_q}, 32'd0);
    check_eq("t5_sb_empty", sb.size(),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
